axil2reg_bridge: RTL

AXIL2REG_BRIDGE -- requirements
Module: axil2reg_bridge

---
 rtl/axil2reg_bridge_if.sv | 63 ++++++
 rtl/axil2reg_bridge.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/axil2reg_bridge_if.sv
// Bus interfaces for the AXI4-Lite to register-bus bridge.
// AXI4Lite carries the five AXI4-Lite channels; REG_BUS is a pulse-strobed register port.

interface AXI4Lite #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

interface REG_BUS #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    wren;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    rden;
    logic [ADDR_WIDTH-1:0]   raddr;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvld;

    modport master (
        output wren, waddr, wdata, wstrb, rden, raddr,
        input  rdata, rvld
    );

    modport slave (
        input  wren, waddr, wdata, wstrb, rden, raddr,
        output rdata, rvld
    );
endinterface

// File: rtl/axil2reg_bridge.sv
// AXI4-Lite responder that turns each write/read into a single-cycle register-bus strobe.
// Independent write and read FSMs, one transaction of each kind in flight.

module axil2reg_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input logic    clk,
    input logic    rst,
    AXI4Lite.slave s_axil,
    REG_BUS.master m_reg
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = $clog2(RD_TIMEOUT + 1);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rstate_t;

    wstate_t               wstate;
    rstate_t               rstate;
    logic                  have_aw;
    logic                  have_w;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [CNT_W-1:0]      wait_cnt;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  aw_got;
    logic                  w_got;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [DATA_WIDTH-1:0] issue_data;
    logic [STRB_W-1:0]     issue_strb;
    logic                  unused_prot;

    assign aw_hs  = s_axil.awvalid & s_axil.awready;
    assign w_hs   = s_axil.wvalid & s_axil.wready;
    assign ar_hs  = s_axil.arvalid & s_axil.arready;
    assign aw_got = have_aw | aw_hs;
    assign w_got  = have_w | w_hs;

    // A handshake in the completing cycle bypasses the capture registers
    assign issue_addr = aw_hs ? s_axil.awaddr : awaddr_q;
    assign issue_data = w_hs ? s_axil.wdata : wdata_q;
    assign issue_strb = w_hs ? s_axil.wstrb : wstrb_q;

    assign unused_prot = ^{s_axil.awprot, s_axil.arprot};

    // Write FSM: collect AW and W in any order, pulse wren, then return OKAY on B
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate         <= W_IDLE;
            have_aw        <= 1'b0;
            have_w         <= 1'b0;
            awaddr_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            s_axil.awready <= 1'b0;
            s_axil.wready  <= 1'b0;
            s_axil.bvalid  <= 1'b0;
            s_axil.bresp   <= OKAY;
            m_reg.wren     <= 1'b0;
            m_reg.waddr    <= '0;
            m_reg.wdata    <= '0;
            m_reg.wstrb    <= '0;
        end else begin
            m_reg.wren  <= 1'b0;
            m_reg.waddr <= '0;
            m_reg.wdata <= '0;
            m_reg.wstrb <= '0;
            case (wstate)
                W_IDLE: begin
                    if (aw_hs) awaddr_q <= s_axil.awaddr;
                    if (w_hs) begin
                        wdata_q <= s_axil.wdata;
                        wstrb_q <= s_axil.wstrb;
                    end
                    if (aw_got && w_got) begin
                        wstate         <= W_ISSUE;
                        have_aw        <= 1'b0;
                        have_w         <= 1'b0;
                        s_axil.awready <= 1'b0;
                        s_axil.wready  <= 1'b0;
                        m_reg.wren     <= 1'b1;
                        m_reg.waddr    <= issue_addr;
                        m_reg.wdata    <= issue_data;
                        m_reg.wstrb    <= issue_strb;
                    end else begin
                        have_aw        <= aw_got;
                        have_w         <= w_got;
                        s_axil.awready <= ~aw_got;
                        s_axil.wready  <= ~w_got;
                    end
                end
                W_ISSUE: begin
                    wstate        <= W_RESP;
                    s_axil.bvalid <= 1'b1;
                    s_axil.bresp  <= OKAY;
                end
                W_RESP: begin
                    if (s_axil.bready) begin
                        wstate         <= W_IDLE;
                        s_axil.bvalid  <= 1'b0;
                        s_axil.awready <= 1'b1;
                        s_axil.wready  <= 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: pulse rden, take the first rvld or time out with SLVERR
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate         <= R_IDLE;
            wait_cnt       <= '0;
            s_axil.arready <= 1'b0;
            s_axil.rvalid  <= 1'b0;
            s_axil.rdata   <= '0;
            s_axil.rresp   <= OKAY;
            m_reg.rden     <= 1'b0;
            m_reg.raddr    <= '0;
        end else begin
            m_reg.rden  <= 1'b0;
            m_reg.raddr <= '0;
            case (rstate)
                R_IDLE: begin
                    s_axil.arready <= 1'b1;
                    if (ar_hs) begin
                        rstate         <= R_ISSUE;
                        s_axil.arready <= 1'b0;
                        m_reg.rden     <= 1'b1;
                        m_reg.raddr    <= s_axil.araddr;
                    end
                end
                R_ISSUE: begin
                    wait_cnt <= '0;
                    if (m_reg.rvld) begin
                        rstate        <= R_RESP;
                        s_axil.rvalid <= 1'b1;
                        s_axil.rdata  <= m_reg.rdata;
                        s_axil.rresp  <= OKAY;
                    end else begin
                        rstate <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (m_reg.rvld) begin
                        rstate        <= R_RESP;
                        s_axil.rvalid <= 1'b1;
                        s_axil.rdata  <= m_reg.rdata;
                        s_axil.rresp  <= OKAY;
                    end else if (wait_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                        rstate        <= R_RESP;
                        s_axil.rvalid <= 1'b1;
                        s_axil.rdata  <= DATA_WIDTH'(32'hDEAD_BEEF);
                        s_axil.rresp  <= SLVERR;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                R_RESP: begin
                    if (s_axil.rready) begin
                        rstate         <= R_IDLE;
                        s_axil.rvalid  <= 1'b0;
                        s_axil.rdata   <= '0;
                        s_axil.rresp   <= OKAY;
                        s_axil.arready <= 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule
